// File: rtl/pd_grant_if.sv
// Handshake bundle between the priority-encoder side and the pd_grant decoder.
// The master side presents the index and ack. The slave side is the decoder driving grant and status.
interface pd_grant_if;
  logic [3:0]  in_idx;
  logic        in_valid;
  logic        in_ready;
  logic        ack;
  logic        clr_err;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        done;
  logic        timeout;
  logic        err;

  modport master (
    output in_idx, in_valid, ack, clr_err,
    input  in_ready, grant, grant_idx, done, timeout, err
  );

  modport slave (
    input  in_idx, in_valid, ack, clr_err,
    output in_ready, grant, grant_idx, done, timeout, err
  );
endinterface

// File: rtl/pd_grant.sv
// Decodes an encoded 4-bit request index into a registered one-hot grant.
// The grant is held for at least MIN_HOLD cycles, until ack, or until TIMEOUT cycles elapse.
module pd_grant #(
  parameter int unsigned MIN_HOLD = 2,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  pd_grant_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] MIN_M1 = 8'(MIN_HOLD - 1);
  localparam logic [7:0] TO_M1  = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  hold_cnt;
  logic        ack_seen;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        done;
  logic        timeout;
  logic        err;
  logic        rel;

  always_comb begin
    rel           = bus.ack | ack_seen;
    bus.in_ready  = (state == IDLE);
    bus.grant     = grant;
    bus.grant_idx = grant_idx;
    bus.done      = done;
    bus.timeout   = timeout;
    bus.err       = err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err       <= 1'b0;
      hold_cnt  <= '0;
      ack_seen  <= 1'b0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      // A clear is overridden below by a timeout on the same edge.
      if (bus.clr_err) err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            grant     <= 16'b1 << bus.in_idx;
            grant_idx <= bus.in_idx;
            hold_cnt  <= '0;
            ack_seen  <= 1'b0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + 8'd1;
          if (rel && hold_cnt >= MIN_M1) begin
            grant <= '0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            if (bus.ack) ack_seen <= 1'b1;
            if (hold_cnt == TO_M1) begin
              grant   <= '0;
              timeout <= 1'b1;
              err     <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pd_grant.sv
// Directed bench for pd_grant: a per-cycle vector table followed by hand-written
// timeout, ack-at-timeout and asynchronous-reset sequences.
module tb_pd_grant;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  pd_grant_if bus ();

  pd_grant #(.MIN_HOLD(2), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  idx;
    logic        ack;
    logic        clr;
    logic [15:0] g;
    logic [3:0]  gi;
    logic        rdy;
    logic        dn;
    logic        to;
    logic        er;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] g, input logic [3:0] gi,
                            input logic rdy, input logic dn, input logic to, input logic er);
    chk({tag, ".grant"},     32'(bus.grant),     32'(g));
    chk({tag, ".grant_idx"}, 32'(bus.grant_idx), 32'(gi));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(rdy));
    chk({tag, ".done"},      32'(bus.done),      32'(dn));
    chk({tag, ".timeout"},   32'(bus.timeout),   32'(to));
    chk({tag, ".err"},       32'(bus.err),       32'(er));
    chk({tag, ".onehot"},    32'($onehot0(bus.grant)), 32'(1));
  endtask

  task automatic step(input logic v, input logic [3:0] idx, input logic a, input logic c);
    bus.in_valid = v;
    bus.in_idx   = idx;
    bus.ack      = a;
    bus.clr_err  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_idx   = '0;
    bus.ack      = 1'b0;
    bus.clr_err  = 1'b0;

    //            v  idx   ack clr  grant     gi    rdy dn to er
    vecs[0]  = '{1, 4'd9, 0, 0, 16'h0200, 4'd9, 0, 0, 0, 0};
    vecs[1]  = '{0, 4'd0, 0, 0, 16'h0200, 4'd9, 0, 0, 0, 0};
    vecs[2]  = '{0, 4'd0, 0, 0, 16'h0200, 4'd9, 0, 0, 0, 0};
    vecs[3]  = '{0, 4'd0, 1, 0, 16'h0000, 4'd9, 1, 1, 0, 0};
    vecs[4]  = '{0, 4'd0, 0, 0, 16'h0000, 4'd9, 1, 0, 0, 0};
    vecs[5]  = '{1, 4'd0, 0, 0, 16'h0001, 4'd0, 0, 0, 0, 0};
    vecs[6]  = '{0, 4'd0, 1, 0, 16'h0001, 4'd0, 0, 0, 0, 0};
    vecs[7]  = '{0, 4'd0, 0, 0, 16'h0000, 4'd0, 1, 1, 0, 0};
    vecs[8]  = '{0, 4'd0, 0, 1, 16'h0000, 4'd0, 1, 0, 0, 0};
    vecs[9]  = '{1, 4'd5, 0, 0, 16'h0020, 4'd5, 0, 0, 0, 0};
    vecs[10] = '{1, 4'd3, 0, 0, 16'h0020, 4'd5, 0, 0, 0, 0};
    vecs[11] = '{1, 4'd3, 1, 0, 16'h0000, 4'd5, 1, 1, 0, 0};
    vecs[12] = '{1, 4'd3, 0, 0, 16'h0008, 4'd3, 0, 0, 0, 0};
    vecs[13] = '{0, 4'd0, 1, 0, 16'h0008, 4'd3, 0, 0, 0, 0};
    vecs[14] = '{0, 4'd0, 0, 0, 16'h0000, 4'd3, 1, 1, 0, 0};
    vecs[15] = '{0, 4'd0, 0, 0, 16'h0000, 4'd3, 1, 0, 0, 0};

    // Reset, then idle
    #2;
    check_outs("in_reset", 16'h0, 4'd0, 1, 0, 0, 0);
    #10 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(0, 4'd0, 0, 0);
      check_outs($sformatf("idle%0d", i), 16'h0, 4'd0, 1, 0, 0, 0);
    end

    // Table: basic grant, early ack, busy with held request
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].v, vecs[i].idx, vecs[i].ack, vecs[i].clr);
      check_outs($sformatf("vec%0d", i), vecs[i].g, vecs[i].gi, vecs[i].rdy,
                 vecs[i].dn, vecs[i].to, vecs[i].er);
    end

    // Timeout: grant held exactly 15 cycles
    step(1, 4'd15, 0, 0);
    check_outs("to_acc", 16'h8000, 4'd15, 0, 0, 0, 0);
    for (int i = 1; i < 15; i++) begin
      step(0, 4'd0, 0, 0);
      check_outs($sformatf("to_hold%0d", i), 16'h8000, 4'd15, 0, 0, 0, 0);
    end
    step(0, 4'd0, 0, 0);
    check_outs("to_fire", 16'h0, 4'd15, 1, 0, 1, 1);
    step(0, 4'd0, 0, 0);
    check_outs("to_sticky", 16'h0, 4'd15, 1, 0, 0, 1);

    // Timeout coinciding with clr_err: err stays set
    step(1, 4'd7, 0, 0);
    for (int i = 1; i < 15; i++) step(0, 4'd0, 0, 0);
    check_outs("to2_last", 16'h0080, 4'd7, 0, 0, 0, 1);
    step(0, 4'd0, 0, 1);
    check_outs("to2_clr_vs_set", 16'h0, 4'd7, 1, 0, 1, 1);
    step(0, 4'd0, 0, 1);
    check_outs("err_cleared", 16'h0, 4'd7, 1, 0, 0, 0);

    // Ack on the timeout edge: release wins
    step(1, 4'd12, 0, 0);
    for (int i = 1; i < 15; i++) step(0, 4'd0, 0, 0);
    check_outs("ackto_pre", 16'h1000, 4'd12, 0, 0, 0, 0);
    step(0, 4'd0, 1, 0);
    check_outs("ackto_edge", 16'h0, 4'd12, 1, 1, 0, 0);

    // Asynchronous reset mid-grant
    step(1, 4'd5, 0, 0);
    step(0, 4'd0, 0, 0);
    check_outs("ar_pre", 16'h0020, 4'd5, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs("ar_async", 16'h0, 4'd0, 1, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 4'd2, 0, 0);
    check_outs("ar_after", 16'h0004, 4'd2, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
